uvmt_cv32e40s_obi_latency_monitor: RTL and testbench

Parametrised multi-channel OBI response-latency monitor for the cv32e40s verification environment. It sits beside the core's OBI instruction and data ports. Per channel, it tracks accepted address phases and retired response phases, holds a per-transaction age in an in-order tracking queue, and raises sticky error flags. Flags fire on response latency beyond a configurable stall bound, on outstanding-queue overflow, and on orphan responses. Assertion and coverage modules consume its outputs in place of ad-hoc occurrence counters.

---
 rtl/uvmt_cv32e40s_obi_lat_pkg.sv | 17 +
 rtl/uvmt_cv32e40s_obi_lat_channel.sv | 79 +++++++
 rtl/uvmt_cv32e40s_obi_latency_monitor.sv | 65 ++++++
 tb/tb_uvmt_cv32e40s_obi_latency_monitor.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uvmt_cv32e40s_obi_lat_pkg.sv
// uvmt_cv32e40s_obi_lat_pkg: shared types, channel indices and width helper for the OBI latency monitor.
package uvmt_cv32e40s_obi_lat_pkg;

    localparam int CH_INSTR = 0;
    localparam int CH_DATA  = 1;

    typedef struct packed {
        logic latency;
        logic overflow;
        logic underflow;
    } obi_lat_err_t;

    function automatic int lat_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uvmt_cv32e40s_obi_lat_channel.sv
// uvmt_cv32e40s_obi_lat_channel: one OBI channel's in-order age queue, phase counters and sticky error flags.
module uvmt_cv32e40s_obi_lat_channel
    import uvmt_cv32e40s_obi_lat_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_STALLS      = 8,
    parameter int CNT_W           = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clr_i,
    input  logic                                  req_i,
    input  logic                                  gnt_i,
    input  logic                                  rvalid_i,
    output logic [CNT_W-1:0]                      aph_cnt_o,
    output logic [CNT_W-1:0]                      rph_cnt_o,
    output logic [lat_width(MAX_OUTSTANDING)-1:0] outstanding_o,
    output logic [lat_width(MAX_STALLS+1)-1:0]    head_age_o,
    output logic [lat_width(MAX_STALLS+1)-1:0]    max_stall_o,
    output obi_lat_err_t                          err_o
);

    localparam int OCC_W = lat_width(MAX_OUTSTANDING);
    localparam int AGE_W = lat_width(MAX_STALLS + 1);
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(MAX_STALLS + 1);
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(MAX_STALLS);

    logic [AGE_W-1:0] ages   [MAX_OUTSTANDING];
    logic [AGE_W-1:0] ages_n [MAX_OUTSTANDING];
    logic [AGE_W-1:0] ext    [MAX_OUTSTANDING+1];
    logic             acc, pop, push, empty, full;
    logic [OCC_W-1:0] keep;
    obi_lat_err_t     set;

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_SAT) ? a : a + 1'b1;
    endfunction

    // Slots at or beyond the post-pop occupancy are held at zero, so a push needs no explicit write.
    always_comb begin
        acc           = req_i && gnt_i;
        empty         = outstanding_o == '0;
        full          = outstanding_o == OCC_W'(MAX_OUTSTANDING);
        pop           = rvalid_i && !empty;
        push          = acc && (!full || pop);
        keep          = outstanding_o - OCC_W'(pop);
        set.latency   = !empty && !rvalid_i && ages[0] == AGE_LIM;
        set.overflow  = acc && full && !pop;
        set.underflow = rvalid_i && empty;
        for (int i = 0; i < MAX_OUTSTANDING; i++) ext[i] = ages[i];
        ext[MAX_OUTSTANDING] = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            ages_n[i] = '0;
            if (OCC_W'(i) < keep) ages_n[i] = sat_inc(pop ? ext[i+1] : ext[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aph_cnt_o     <= '0;
            rph_cnt_o     <= '0;
            outstanding_o <= '0;
            ages          <= '{default: '0};
            max_stall_o   <= '0;
            err_o         <= '0;
        end else begin
            aph_cnt_o     <= aph_cnt_o + CNT_W'(acc);
            rph_cnt_o     <= rph_cnt_o + CNT_W'(rvalid_i);
            outstanding_o <= keep + OCC_W'(push);
            ages          <= ages_n;
            max_stall_o   <= clr_i ? (pop ? ages[0] : '0)
                                   : ((pop && ages[0] > max_stall_o) ? ages[0] : max_stall_o);
            err_o         <= (clr_i ? '0 : err_o) | set;
        end
    end

    assign head_age_o = ages[0];

endmodule

// File: rtl/uvmt_cv32e40s_obi_latency_monitor.sv
// uvmt_cv32e40s_obi_latency_monitor: multi-channel OBI response-latency monitor with sticky error flags.
// Define UVMT_OBI_LAT_ASSERT_EN to add per-channel error assertions and head-age covers.
module uvmt_cv32e40s_obi_latency_monitor
    import uvmt_cv32e40s_obi_lat_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_STALLS      = 8,
    parameter int CNT_W           = 32
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              clr_i,
    input  logic [NUM_CH-1:0]                                 req_i,
    input  logic [NUM_CH-1:0]                                 gnt_i,
    input  logic [NUM_CH-1:0]                                 rvalid_i,
    output logic [NUM_CH-1:0][CNT_W-1:0]                      aph_cnt_o,
    output logic [NUM_CH-1:0][CNT_W-1:0]                      rph_cnt_o,
    output logic [NUM_CH-1:0][lat_width(MAX_OUTSTANDING)-1:0] outstanding_o,
    output logic [NUM_CH-1:0][lat_width(MAX_STALLS+1)-1:0]    head_age_o,
    output logic [NUM_CH-1:0][lat_width(MAX_STALLS+1)-1:0]    max_stall_o,
    output logic [NUM_CH-1:0]                                 err_latency_o,
    output logic [NUM_CH-1:0]                                 err_overflow_o,
    output logic [NUM_CH-1:0]                                 err_underflow_o
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        obi_lat_err_t err;

        uvmt_cv32e40s_obi_lat_channel #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING),
            .MAX_STALLS     (MAX_STALLS),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .clr_i        (clr_i),
            .req_i        (req_i[g]),
            .gnt_i        (gnt_i[g]),
            .rvalid_i     (rvalid_i[g]),
            .aph_cnt_o    (aph_cnt_o[g]),
            .rph_cnt_o    (rph_cnt_o[g]),
            .outstanding_o(outstanding_o[g]),
            .head_age_o   (head_age_o[g]),
            .max_stall_o  (max_stall_o[g]),
            .err_o        (err)
        );

        assign err_latency_o[g]   = err.latency;
        assign err_overflow_o[g]  = err.overflow;
        assign err_underflow_o[g] = err.underflow;

`ifdef UVMT_OBI_LAT_ASSERT_EN
        a_latency: assert property (@(posedge clk_i) disable iff (rst_i) !$rose(err_latency_o[g]))
            else $error("obi channel %0d: response latency bound exceeded", g);
        a_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !$rose(err_overflow_o[g]))
            else $error("obi channel %0d: outstanding queue overflow", g);
        a_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !$rose(err_underflow_o[g]))
            else $error("obi channel %0d: orphan response", g);
        c_head_age_lim: cover property (@(posedge clk_i) disable iff (rst_i)
            head_age_o[g] == lat_width(MAX_STALLS+1)'(MAX_STALLS));
`endif
    end

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_latency_monitor.sv
// tb_uvmt_cv32e40s_obi_latency_monitor: table-driven directed checks plus hand sequences for latency, overflow and counters.
module tb_uvmt_cv32e40s_obi_latency_monitor;

    logic             clk_i = 1'b0;
    logic             rst_i, clr_i;
    logic [1:0]       req_i, gnt_i, rvalid_i;
    logic [1:0][31:0] aph_cnt_o, rph_cnt_o;
    logic [1:0][1:0]  outstanding_o;
    logic [1:0][3:0]  head_age_o, max_stall_o;
    logic [1:0]       err_latency_o, err_overflow_o, err_underflow_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst;
        logic       clr;
        logic [1:0] acc;
        logic [1:0] rv;
        logic [1:0] out0;
        logic [3:0] age0;
        logic [3:0] mst0;
        logic [1:0] ovf;
        logic [1:0] und;
    } vec_t;

    vec_t vecs [17];

    uvmt_cv32e40s_obi_latency_monitor dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clr_i          (clr_i),
        .req_i          (req_i),
        .gnt_i          (gnt_i),
        .rvalid_i       (rvalid_i),
        .aph_cnt_o      (aph_cnt_o),
        .rph_cnt_o      (rph_cnt_o),
        .outstanding_o  (outstanding_o),
        .head_age_o     (head_age_o),
        .max_stall_o    (max_stall_o),
        .err_latency_o  (err_latency_o),
        .err_overflow_o (err_overflow_o),
        .err_underflow_o(err_underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input logic r, input logic c, input logic [1:0] a, input logic [1:0] v);
        rst_i    = r;
        clr_i    = c;
        req_i    = a;
        gnt_i    = a;
        rvalid_i = v;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_i = 1'b0; clr_i = 1'b0; req_i = '0; gnt_i = '0; rvalid_i = '0;
        //            rst clr acc    rv     out0  age0 mst0 ovf    und
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'd0, 4'd0, 4'd0, 2'b00, 2'b00};
        vecs[1]  = '{1'b0, 1'b0, 2'b01, 2'b00, 2'd1, 4'd0, 4'd0, 2'b00, 2'b00};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 2'b01, 2'd0, 4'd0, 4'd0, 2'b00, 2'b00};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 2'b00, 2'd1, 4'd0, 4'd0, 2'b00, 2'b00};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 2'b00, 2'd2, 4'd1, 4'd0, 2'b00, 2'b00};
        vecs[5]  = '{1'b0, 1'b0, 2'b01, 2'b00, 2'd2, 4'd2, 4'd0, 2'b01, 2'b00};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 2'b01, 2'd1, 4'd2, 4'd2, 2'b01, 2'b00};
        vecs[7]  = '{1'b0, 1'b0, 2'b01, 2'b01, 2'd1, 4'd0, 4'd2, 2'b01, 2'b00};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 2'b01, 2'd0, 4'd0, 4'd2, 2'b01, 2'b00};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 2'b01, 2'd0, 4'd0, 4'd2, 2'b01, 2'b01};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 4'd0, 4'd0, 2'b00, 2'b00};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 2'b01, 2'd0, 4'd0, 4'd0, 2'b00, 2'b01};
        vecs[12] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'd0, 4'd0, 4'd0, 2'b00, 2'b00};
        vecs[13] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'd1, 4'd0, 4'd0, 2'b00, 2'b01};
        vecs[14] = '{1'b0, 1'b0, 2'b01, 2'b00, 2'd2, 4'd1, 4'd0, 2'b00, 2'b01};
        vecs[15] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'd0, 4'd0, 4'd0, 2'b00, 2'b00};
        vecs[16] = '{1'b0, 1'b0, 2'b00, 2'b01, 2'd0, 4'd0, 4'd0, 2'b00, 2'b01};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].acc, vecs[i].rv);
            chk($sformatf("vec%0d", i),
                {outstanding_o[0], head_age_o[0], max_stall_o[0], err_overflow_o, err_underflow_o,
                 err_latency_o, outstanding_o[1], head_age_o[1]},
                {vecs[i].out0, vecs[i].age0, vecs[i].mst0, vecs[i].ovf, vecs[i].und,
                 2'b00, 2'd0, 4'd0});
        end

        // ch0 counters and overflow after reset
        step(1'b1, 1'b0, 2'b00, 2'b00);
        chk("rst_aph0", aph_cnt_o[0], 64'd0);
        chk("rst_rph0", rph_cnt_o[0], 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, 2'b00);
        chk("ovf_aph0", aph_cnt_o[0], 64'd3);
        chk("ovf_out0", outstanding_o[0], 64'd2);
        chk("ovf_flag", err_overflow_o, 64'b01);
        step(1'b0, 1'b0, 2'b00, 2'b01);
        chk("rph0", rph_cnt_o[0], 64'd1);
        chk("aph1", aph_cnt_o[1], 64'd0);

        // ch0 response at the last legal age
        step(1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b01, 2'b00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'b00, 2'b00);
        chk("age8_head", head_age_o[0], 64'd8);
        chk("age8_nolat", err_latency_o, 64'b00);
        step(1'b0, 1'b0, 2'b00, 2'b01);
        chk("age8_mst", max_stall_o[0], 64'd8);
        chk("age8_out", outstanding_o[0], 64'd0);
        chk("age8_lat", err_latency_o, 64'b00);

        // concurrent channels, only ch1 exceeds the bound
        step(1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b11, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b01);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'b00, 2'b00);
        chk("ch1_age8", head_age_o[1], 64'd8);
        chk("ch1_nolat", err_latency_o, 64'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        chk("ch1_lat", err_latency_o, 64'b10);
        chk("ch1_age_sat", head_age_o[1], 64'd9);
        step(1'b0, 1'b0, 2'b00, 2'b10);
        chk("ch1_mst", max_stall_o[1], 64'd9);
        chk("ch0_mst", max_stall_o[0], 64'd0);
        chk("ch1_out", outstanding_o[1], 64'd0);
        chk("lat_sticky", err_latency_o, 64'b10);
        step(1'b0, 1'b1, 2'b00, 2'b00);
        chk("lat_clr", err_latency_o, 64'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
